parking_stimulus_gen: RTL



---
 rtl/parking_tb_pkg.sv | 53 +++++
 rtl/lfsr8.sv | 26 ++
 rtl/parking_stimulus_gen.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/parking_tb_pkg.sv
// Shared types and constants for the parking-lot stimulus sequencer:
// FSM states, car direction, sensor phase patterns and LFSR taps.
package parking_tb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_POST,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } gen_state_t;

    typedef enum logic {
        EXIT  = 1'b0,
        ENTRY = 1'b1
    } dir_t;

    // Sensor pairs are packed as {a, b}.
    localparam logic [1:0] SENS_IDLE = 2'b00;
    localparam logic [1:0] ENTRY_SEQ [3] = '{2'b10, 2'b11, 2'b01};
    localparam logic [1:0] EXIT_SEQ  [3] = '{2'b01, 2'b11, 2'b10};

    // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci: feedback from bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic dir_t pick_dir(input logic [3:0] count, input logic [3:0] max_count,
                                      input logic lfsr_bit);
        dir_t d;
        if (count == 4'd0)
            d = ENTRY;
        else if (count == max_count)
            d = EXIT;
        else
            d = lfsr_bit ? ENTRY : EXIT;
        return d;
    endfunction

    function automatic logic [1:0] sensor_phase(input gen_state_t st, input dir_t d);
        logic [1:0] p;
        case (st)
            ST_S1:   p = (d == ENTRY) ? ENTRY_SEQ[0] : EXIT_SEQ[0];
            ST_S2:   p = (d == ENTRY) ? ENTRY_SEQ[1] : EXIT_SEQ[1];
            ST_S3:   p = (d == ENTRY) ? ENTRY_SEQ[2] : EXIT_SEQ[2];
            default: p = SENS_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR used for the entry/exit direction choice.
// An all-zero seed would lock up, so it is replaced by 8'h01.
module lfsr8
    import parking_tb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_reg;
    logic       feedback;

    assign feedback = ^(q_reg & LFSR_TAPS);
    assign q        = q_reg;

    always_ff @(posedge clk) begin
        if (reset)
            q_reg <= (seed == 8'h00) ? 8'h01 : seed;
        else if (advance)
            q_reg <= {q_reg[6:0], feedback};
    end

endmodule

// File: rtl/parking_stimulus_gen.sv
// Stimulus sequencer for the parking-lot FSM: plays legal entry/exit sensor sequences,
// tracks the reference occupancy and pulses check after every completed car event.
module parking_stimulus_gen
    import parking_tb_pkg::*;
#(
    parameter int         NUM_EVENTS    = 12,
    parameter int         HOLD_CYCLES   = 2,
    parameter int         SETTLE_CYCLES = 3,
    parameter int         MAX_COUNT     = 15,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       check,
    output logic       finish,
    output logic [3:0] expected_count,
    output logic       busy,
    output logic [7:0] event_idx
);

    localparam int            CW          = 16;
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [7:0]    EVENTS_LAST = 8'(NUM_EVENTS);
    localparam logic [3:0]    MAX_CNT     = 4'(MAX_COUNT);

    gen_state_t    state_reg, state_next;
    dir_t          dir_reg, dir_next;
    logic [CW-1:0] timer_reg, timer_next;
    logic [3:0]    count_reg, count_next;
    logic [7:0]    idx_reg, idx_next;
    logic          a_reg, a_next;
    logic          b_reg, b_next;
    logic          check_reg, check_next;
    logic          finish_reg, finish_next;
    logic          busy_reg, busy_next;
    logic          advance;
    logic          timer_done;
    logic [7:0]    lfsr_q;

    lfsr8 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .seed    (LFSR_SEED),
        .q       (lfsr_q)
    );

    assign timer_done = (timer_reg == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            dir_reg    <= ENTRY;
            timer_reg  <= '0;
            count_reg  <= 4'd0;
            idx_reg    <= 8'd0;
            a_reg      <= 1'b0;
            b_reg      <= 1'b0;
            check_reg  <= 1'b0;
            finish_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            dir_reg    <= dir_next;
            timer_reg  <= timer_next;
            count_reg  <= count_next;
            idx_reg    <= idx_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            check_reg  <= check_next;
            finish_reg <= finish_next;
            busy_reg   <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        timer_next = timer_done ? '0 : timer_reg - CW'(1);
        count_next = count_reg;
        idx_next   = idx_reg;
        advance    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_PRE;
                    timer_next = HOLD_LOAD;
                    dir_next   = pick_dir(count_reg, MAX_CNT, lfsr_q[0]);
                    advance    = 1'b1;
                end
            end
            ST_PRE: if (timer_done) begin
                state_next = ST_S1;
                timer_next = HOLD_LOAD;
            end
            ST_S1: if (timer_done) begin
                state_next = ST_S2;
                timer_next = HOLD_LOAD;
            end
            ST_S2: if (timer_done) begin
                state_next = ST_S3;
                timer_next = HOLD_LOAD;
            end
            ST_S3: if (timer_done) begin
                // Direction forcing at PRE keeps the count inside 0..MAX_COUNT.
                state_next = ST_POST;
                timer_next = HOLD_LOAD;
                count_next = (dir_reg == ENTRY) ? count_reg + 4'd1 : count_reg - 4'd1;
            end
            ST_POST: if (timer_done) begin
                state_next = ST_SETTLE;
                timer_next = SETTLE_LOAD;
            end
            ST_SETTLE: if (timer_done) begin
                state_next = ST_CHECK;
            end
            ST_CHECK: begin
                idx_next = idx_reg + 8'd1;
                if (idx_next == EVENTS_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_PRE;
                    timer_next = HOLD_LOAD;
                    dir_next   = pick_dir(count_reg, MAX_CNT, lfsr_q[0]);
                    advance    = 1'b1;
                end
            end
            ST_DONE: ;
            default: state_next = ST_IDLE;
        endcase

        // Outputs are registered copies of what the next state presents.
        {a_next, b_next} = sensor_phase(state_next, dir_next);
        check_next       = (state_next == ST_CHECK);
        finish_next      = (state_next == ST_DONE);
        busy_next        = (state_next != ST_IDLE) && (state_next != ST_DONE);
    end

    assign a              = a_reg;
    assign b              = b_reg;
    assign check          = check_reg;
    assign finish         = finish_reg;
    assign busy           = busy_reg;
    assign expected_count = count_reg;
    assign event_idx      = idx_reg;

endmodule
